// File: rtl/axi_wr_packer.sv
// -----------------------------------------------------------------------------
// axi_wr_packer
//
// Write-path front end of the AXI clock-crossing FIFO. The AW and W channels
// are merged into one ordered packet stream, so the async FIFO only has to
// carry a single channel. Each burst becomes one header beat holding the AW
// fields, followed by AWLEN+1 data beats holding {WSTRB, WDATA}. A W burst
// always follows its own AW because W is only accepted after the header has
// been taken.
//
// Parameters
//   ADDR_WIDTH   AW address width
//   DATA_WIDTH   W data width (STRB_WIDTH = DATA_WIDTH/8)
//   ID_WIDTH     AW ID width
//   PKT_WIDTH    derived, DATA_WIDTH + STRB_WIDTH. The header must fit into it.
//
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   aw_valid_i / aw_ready_o            AW handshake
//   aw_id_i, aw_addr_i, aw_len_i,
//   aw_size_i, aw_burst_i              AW payload
//   w_valid_i / w_ready_o              W handshake
//   w_data_i, w_strb_i, w_last_i       W payload
//   pkt_valid_o / pkt_ready_i          packet stream handshake (FIFO write side)
//   pkt_hdr_o                          1 = header beat
//   pkt_last_o                         1 = final data beat of the burst
//   pkt_data_o                         header: {0, burst, size, len, id, addr}
//                                      data:   {strb, data}
//   busy_o                             burst in progress or beat held at output
//   err_o                              sticky WLAST framing error
//
// Build option
//   AXI_WR_PACK_ERR_EN  when defined, err_o flags any accepted W beat whose
//                       WLAST disagrees with the AWLEN-based framing. When
//                       not defined, err_o is tied low and no checker exists.
//
// Framing is taken from AWLEN only; WLAST never ends or extends a burst.
// -----------------------------------------------------------------------------
module axi_wr_packer #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 64,
    parameter  int ID_WIDTH   = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int PKT_WIDTH  = DATA_WIDTH + DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,

    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [STRB_WIDTH-1:0] w_strb_i,
    input  logic                  w_last_i,

    output logic                  pkt_valid_o,
    input  logic                  pkt_ready_i,
    output logic                  pkt_hdr_o,
    output logic                  pkt_last_o,
    output logic [PKT_WIDTH-1:0]  pkt_data_o,

    output logic                  busy_o,
    output logic                  err_o
);

    // state | meaning
    // ------+-------------------------------------------------------------
    // IDLE  | waiting for an AW; W is held off
    // DATA  | header taken, passing W beats until beat_cnt reaches zero
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    localparam int HDR_WIDTH = ADDR_WIDTH + ID_WIDTH + 13;

    if (HDR_WIDTH > PKT_WIDTH) begin : g_hdr_too_wide
        $error("axi_wr_packer: header (ADDR_WIDTH+ID_WIDTH+13) does not fit in PKT_WIDTH");
    end

    state_e                 state_q,     state_d;
    logic [7:0]             beat_cnt_q,  beat_cnt_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic                   pkt_hdr_q,   pkt_hdr_d;
    logic                   pkt_last_q,  pkt_last_d;
    logic [PKT_WIDTH-1:0]   pkt_data_q,  pkt_data_d;

    logic                   load_en;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   cnt_zero;
    logic [PKT_WIDTH-1:0]   hdr_word;

    // The output register can take a new beat when it is empty or its
    // current beat is leaving this cycle.
    assign load_en    = !pkt_valid_q || pkt_ready_i;
    assign aw_ready_o = (state_q == ST_IDLE) && load_en;
    assign w_ready_o  = (state_q == ST_DATA) && load_en;
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign w_hs       = w_valid_i && w_ready_o;
    assign cnt_zero   = (beat_cnt_q == 8'd0);

    always_comb begin
        hdr_word                = '0;
        hdr_word[HDR_WIDTH-1:0] = {aw_burst_i, aw_size_i, aw_len_i, aw_id_i, aw_addr_i};
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_valid_d = pkt_valid_q;
        pkt_hdr_d   = pkt_hdr_q;
        pkt_last_d  = pkt_last_q;
        pkt_data_d  = pkt_data_q;

        // Beat consumed with nothing new behind it: drop valid, keep contents.
        if (load_en) begin
            pkt_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    pkt_valid_d = 1'b1;
                    pkt_hdr_d   = 1'b1;
                    pkt_last_d  = 1'b0;
                    pkt_data_d  = hdr_word;
                    beat_cnt_d  = aw_len_i;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    pkt_valid_d = 1'b1;
                    pkt_hdr_d   = 1'b0;
                    pkt_last_d  = cnt_zero;
                    pkt_data_d  = {w_strb_i, w_data_i};
                    // Count stops at zero on the final beat, so len=255 never wraps.
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef AXI_WR_PACK_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q || (w_hs && (w_last_i != cnt_zero));
    assign err_o = err_q;
`else
    logic unused_w_last;

    assign unused_w_last = w_last_i;
    assign err_o         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= 8'd0;
            pkt_valid_q <= 1'b0;
            pkt_hdr_q   <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_data_q  <= '0;
`ifdef AXI_WR_PACK_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_hdr_q   <= pkt_hdr_d;
            pkt_last_q  <= pkt_last_d;
            pkt_data_q  <= pkt_data_d;
`ifdef AXI_WR_PACK_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign pkt_valid_o = pkt_valid_q;
    assign pkt_hdr_o   = pkt_hdr_q;
    assign pkt_last_o  = pkt_last_q;
    assign pkt_data_o  = pkt_data_q;
    assign busy_o      = (state_q != ST_IDLE) || pkt_valid_q;

endmodule

// File: tb/tb_axi_wr_packer.sv
module tb_axi_wr_packer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam int PW = DW + SW;

`ifdef AXI_WR_PACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [2:0]    aw_size_i;
    logic [1:0]    aw_burst_i;
    logic          w_valid_i;
    logic          w_ready_o;
    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic          w_last_i;
    logic          pkt_valid_o;
    logic          pkt_ready_i;
    logic          pkt_hdr_o;
    logic          pkt_last_o;
    logic [PW-1:0] pkt_data_o;
    logic          busy_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    axi_wr_packer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .aw_valid_i  (aw_valid_i),
        .aw_ready_o  (aw_ready_o),
        .aw_id_i     (aw_id_i),
        .aw_addr_i   (aw_addr_i),
        .aw_len_i    (aw_len_i),
        .aw_size_i   (aw_size_i),
        .aw_burst_i  (aw_burst_i),
        .w_valid_i   (w_valid_i),
        .w_ready_o   (w_ready_o),
        .w_data_i    (w_data_i),
        .w_strb_i    (w_strb_i),
        .w_last_i    (w_last_i),
        .pkt_valid_o (pkt_valid_o),
        .pkt_ready_i (pkt_ready_i),
        .pkt_hdr_o   (pkt_hdr_o),
        .pkt_last_o  (pkt_last_o),
        .pkt_data_o  (pkt_data_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    aw_t           aw_q[$];
    w_t            w_q[$];
    logic [PW+1:0] exp_q[$];   // {hdr, last, pkt_data}

    int checks   = 0;
    int failures = 0;

    // Reference model: beats still owed by the accepted burst, expected
    // output valid, expected sticky error, and the beat seen while stalled.
    int            rem        = 0;
    logic          vexp       = 1'b0;
    logic          err_model  = 1'b0;
    logic          stall_prev = 1'b0;
    logic [PW+1:0] held       = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic add_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input bit bad_first_last);
        aw_t           a;
        w_t            w;
        logic [PW-1:0] h;
        a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
        aw_q.push_back(a);
        h = '0;
        h[31:0]  = addr;
        h[35:32] = id;
        h[43:36] = len;
        h[46:44] = size;
        h[48:47] = burst;
        exp_q.push_back({1'b1, 1'b0, h});
        for (int i = 0; i <= int'(len); i++) begin
            w.data = {$urandom, $urandom};
            w.strb = SW'($urandom);
            w.last = (i == int'(len)) || (bad_first_last && i == 0);
            w_q.push_back(w);
            exp_q.push_back({1'b0, (i == int'(len)), w.strb, w.data});
        end
    endtask

    task automatic add_random_burst();
        logic [7:0] len;
        len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 15));
        add_burst(IW'($urandom), $urandom, len, 3'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic model_reset();
        rem        = 0;
        vexp       = 1'b0;
        err_model  = 1'b0;
        stall_prev = 1'b0;
    endtask

    // Drives all queued bursts with the given valid/ready probabilities and
    // compares the merged stream beat by beat against exp_q.
    task automatic run(input int p_aw, input int p_w, input int p_rdy,
                       input int stall_at, output int cycles);
        int            aw_idx = 0;
        int            w_idx  = 0;
        bit            aw_pend = 1'b0;
        bit            w_pend  = 1'b0;
        bit            aw_hs, w_hs, o_hs, stalled;
        logic [PW+1:0] obs;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 3000) begin
            @(negedge clk_i);
            if (!aw_pend) aw_pend = (aw_idx < aw_q.size()) && ($urandom_range(99) < p_aw);
            if (!w_pend)  w_pend  = (w_idx < w_q.size())   && ($urandom_range(99) < p_w);
            aw_valid_i = aw_pend;
            w_valid_i  = w_pend;
            if (aw_idx < aw_q.size()) begin
                aw_id_i    = aw_q[aw_idx].id;
                aw_addr_i  = aw_q[aw_idx].addr;
                aw_len_i   = aw_q[aw_idx].len;
                aw_size_i  = aw_q[aw_idx].size;
                aw_burst_i = aw_q[aw_idx].burst;
            end
            if (w_idx < w_q.size()) begin
                w_data_i = w_q[w_idx].data;
                w_strb_i = w_q[w_idx].strb;
                w_last_i = w_q[w_idx].last;
            end
            stalled = (stall_at >= 0) && (cycles >= stall_at) && (cycles < stall_at + 4);
            pkt_ready_i = ($urandom_range(99) < p_rdy) && !stalled;
            #1;
            obs = {pkt_hdr_o, pkt_last_o, pkt_data_o};
            chk("valid", pkt_valid_o, vexp);
            chk("ready_busy", {aw_ready_o, w_ready_o, busy_o},
                {(rem == 0) && (!vexp || pkt_ready_i),
                 (rem != 0) && (!vexp || pkt_ready_i),
                 (rem != 0) || vexp});
            chk("err", err_o, err_model);
            if (stall_prev) chk("hold", obs, held);
            aw_hs = aw_valid_i && aw_ready_o;
            w_hs  = w_valid_i && w_ready_o;
            o_hs  = pkt_valid_o && pkt_ready_i;
            if (o_hs) begin
                if (exp_q.size() == 0) chk("extra_beat", obs, '0);
                else                   chk("beat", obs, exp_q.pop_front());
            end
            stall_prev = pkt_valid_o && !pkt_ready_i;
            held       = obs;
            if (aw_hs) rem = int'(aw_len_i) + 1;
            if (w_hs) begin
                if (ERR_EN && (w_last_i != (rem == 1))) err_model = 1'b1;
                rem--;
            end
            vexp = (aw_hs || w_hs) ? 1'b1 : (o_hs ? 1'b0 : vexp);
            @(posedge clk_i);
            if (aw_hs) begin aw_idx++; aw_pend = 1'b0; end
            if (w_hs)  begin w_idx++;  w_pend  = 1'b0; end
            cycles++;
        end
        if (exp_q.size() != 0) chk("timeout", exp_q.size(), 0);
        @(negedge clk_i);
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b0;
        aw_q.delete();
        w_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cyc;

        rst_ni      = 1'b0;
        aw_valid_i  = 1'b0;
        aw_id_i     = '0;
        aw_addr_i   = '0;
        aw_len_i    = '0;
        aw_size_i   = '0;
        aw_burst_i  = '0;
        w_valid_i   = 1'b0;
        w_data_i    = '0;
        w_strb_i    = '0;
        w_last_i    = 1'b0;
        pkt_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_flags", {pkt_valid_o, pkt_hdr_o, pkt_last_o, busy_o, err_o, w_ready_o}, '0);
        chk("rst_data", pkt_data_o, '0);
        chk("rst_aw_ready", aw_ready_o, 1'b1);
        model_reset();

        // Basic burst: hdr + 4 data beats at full rate
        add_burst(4'd3, 32'h1000, 8'd3, 3'd3, 2'd1, 1'b0);
        run(100, 100, 100, -1, cyc);
        chk("basic_cycles", cyc, 6);

        // W offered long before AW
        add_burst(4'd1, 32'h2000, 8'd2, 3'd3, 2'd1, 1'b0);
        add_burst(4'd2, 32'h3000, 8'd1, 3'd2, 2'd0, 1'b0);
        run(15, 100, 100, -1, cyc);

        // Four-cycle downstream stall mid-burst
        add_burst(4'd7, 32'h4000, 8'd3, 3'd3, 2'd1, 1'b0);
        run(100, 100, 100, 3, cyc);
        chk("stall_cycles", cyc, 10);

        // len=0 then len=255 back to back: no bubble beyond the headers
        add_burst(4'd4, 32'h5000, 8'd0, 3'd3, 2'd1, 1'b0);
        add_burst(4'd5, 32'h6000, 8'd255, 3'd3, 2'd1, 1'b0);
        run(100, 100, 100, -1, cyc);
        chk("b2b_cycles", cyc, 260);

        // WLAST on first beat of a 2-beat burst
        add_burst(4'd6, 32'h7000, 8'd1, 3'd3, 2'd1, 1'b1);
        run(100, 100, 100, -1, cyc);
        repeat (2) @(negedge clk_i);
        #1;
        chk("err_sticky", err_o, ERR_EN);

        // Reset during data beat 2 of a len=7 burst
        @(negedge clk_i);
        aw_valid_i  = 1'b1;
        aw_id_i     = 4'd9;
        aw_addr_i   = 32'h8000;
        aw_len_i    = 8'd7;
        aw_size_i   = 3'd3;
        aw_burst_i  = 2'd1;
        w_valid_i   = 1'b1;
        w_data_i    = {$urandom, $urandom};
        w_strb_i    = 8'hff;
        w_last_i    = 1'b0;
        pkt_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        aw_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        w_valid_i = 1'b0;
        #1;
        chk("rst_mid_flags", {pkt_valid_o, pkt_hdr_o, pkt_last_o, busy_o, err_o, w_ready_o}, '0);
        chk("rst_mid_data", pkt_data_o, '0);
        chk("rst_mid_aw_ready", aw_ready_o, 1'b1);
        model_reset();

        // Randomized traffic with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < 5; b++) add_random_burst();
            run($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : -1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
